// File: rtl/menu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | menu_pkg : shared source codes, command bases and width helper        |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package menu_pkg;

   typedef enum logic [2:0] {
      SRC_BTN = 3'd0,
      SRC_BT  = 3'd1,
      SRC_PC  = 3'd2
   } src_e;

   localparam logic [7:0] SCENT_BASE   = 8'h01;
   localparam logic [7:0] TMR_BASE_DEF = 8'h1E;

   // Bits needed to hold values 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_step_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | btn_step_gen : 2-FF sync, rise detect and hold-to-repeat step pulse   |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
module btn_step_gen #(
   parameter int unsigned REPEAT_DLY = 500_000,
   parameter int unsigned REPEAT_PER = 200_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic step_o
);
   import menu_pkg::*;

   localparam int unsigned MAXC  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned CW    = clog2(MAXC + 1);
   localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DLY);
   localparam logic [CW-1:0] PER_C = CW'(REPEAT_PER);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   logic [1:0]    sync_q;
   logic          prev_q;
   logic          active_q;
   logic          rep_q;
   logic [CW-1:0] cnt_q;

   logic          level;
   logic          rise;
   logic          fire;
   logic [CW-1:0] target;

   assign level  = sync_q[1];
   assign rise   = level & ~prev_q;
   assign target = rep_q ? PER_C : DLY_C;
   assign fire   = (REPEAT_DLY != 0) && active_q && level && (cnt_q == target);
   assign step_o = rise | fire;

   // Sync and edge history reset to "pressed" so a button held through
   // reset must be released before it can step again.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= 2'b11;
         prev_q   <= 1'b1;
         active_q <= 1'b0;
         rep_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q <= {sync_q[0], btn_i};
         prev_q <= level;
         if (!level) begin
            active_q <= 1'b0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
         end else if (rise) begin
            active_q <= 1'b1;
            rep_q    <= 1'b0;
            cnt_q    <= ONE_C;
         end else if (fire) begin
            rep_q <= 1'b1;
            cnt_q <= ONE_C;
         end else if (active_q && (REPEAT_DLY != 0)) begin
            cnt_q <= cnt_q + ONE_C;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/menu_select_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | menu_select_arbiter : merges buttons and UART commands into menu regs |
// | Revision            : 1.0                                             |
// +-----------------------------------------------------------------------+
module menu_select_arbiter
   import menu_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 2,
   parameter int unsigned SCENT_CNT    = 3,
   parameter int unsigned TIMER_CNT    = 3,
   parameter int unsigned SCENT_ROT    = 1,
   parameter logic [7:0]  TMR_BASE     = TMR_BASE_DEF,
   parameter logic [31:0] TMR_SRC_MASK = 32'b01,
   parameter int unsigned REPEAT_DLY   = 500_000,
   parameter int unsigned REPEAT_PER   = 200_000,
   parameter int unsigned LOCK_CYC     = 100_000
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          btn_l_i,
   input  logic                          btn_r_i,
   input  logic                          btn_u_i,
   input  logic                          btn_d_i,
   input  logic [NUM_SRC-1:0]            uart_valid_i,
   input  logic [8*NUM_SRC-1:0]          uart_data_i,
   output logic [clog2(SCENT_CNT)-1:0]   sel_scent_o,
   output logic [1:0]                    sel_timer_o,
   output logic                          sel_changed_o,
   output logic [2:0]                    sel_src_o,
   output logic                          btn_locked_o,
   output logic                          cmd_drop_o
);

   localparam int unsigned SW  = clog2(SCENT_CNT);
   localparam int unsigned SIW = clog2(NUM_SRC);
   localparam int unsigned LW  = clog2(LOCK_CYC + 1);

   localparam logic [SW-1:0]      SCENT_MAX = SW'(SCENT_CNT - 1);
   localparam logic [1:0]         TIMER_MAX = 2'(TIMER_CNT - 1);
   localparam logic [LW-1:0]      LOCK_C    = LW'(LOCK_CYC);
   localparam logic [NUM_SRC-1:0] ONE_SRC   = NUM_SRC'(1);

   // Step order: 0=L, 1=R, 2=U, 3=D.
   logic [3:0] btn_raw;
   logic [3:0] step;

   assign btn_raw = {btn_d_i, btn_u_i, btn_r_i, btn_l_i};

   for (genvar b = 0; b < 4; b++) begin : g_btn
      btn_step_gen #(
         .REPEAT_DLY (REPEAT_DLY),
         .REPEAT_PER (REPEAT_PER)
      ) u_step (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .btn_i  (btn_raw[b]),
         .step_o (step[b])
      );
   end

   logic [SW-1:0]  scent_q, scent_d;
   logic [1:0]     timer_q, timer_d;
   logic           changed_q, changed_d;
   logic [2:0]     src_q, src_d;
   logic [LW-1:0]  lock_q, lock_d;
   logic           drop_q, drop_d;

   logic           win_valid;
   logic [SIW-1:0] win_idx;
   logic [7:0]     win_byte;
   logic           scent_hit, tmr_hit;
   logic [SW-1:0]  scent_val;
   logic [1:0]     tmr_val;
   logic           scent_take, tmr_take, accept, btn_ok;

   // Fixed priority: the lowest asserted index wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      for (int s = NUM_SRC - 1; s >= 0; s--) begin
         if (uart_valid_i[s]) begin
            win_valid = 1'b1;
            win_idx   = SIW'(s);
         end
      end
   end

   assign win_byte = uart_data_i[8*win_idx +: 8];
   assign drop_d   = (uart_valid_i & (uart_valid_i - ONE_SRC)) != '0;

   always_comb begin
      scent_hit = 1'b0;
      scent_val = '0;
      tmr_hit   = 1'b0;
      tmr_val   = '0;
      for (int i = 0; i < SCENT_CNT; i++) begin
         if (win_byte == SCENT_BASE + 8'(i)) begin
            scent_hit = 1'b1;
            scent_val = SW'((i + SCENT_CNT - SCENT_ROT) % SCENT_CNT);
         end
      end
      for (int j = 0; j < TIMER_CNT; j++) begin
         if (win_byte == 8'(TMR_BASE << j)) begin
            tmr_hit = 1'b1;
            tmr_val = 2'(j);
         end
      end
   end

   assign scent_take = win_valid & scent_hit;
   assign tmr_take   = win_valid & ~scent_hit & tmr_hit & TMR_SRC_MASK[win_idx];
   assign accept     = scent_take | tmr_take;
   assign btn_ok     = ~(|uart_valid_i) & (lock_q == '0);

   always_comb begin
      scent_d = scent_q;
      timer_d = timer_q;
      if (scent_take) begin
         scent_d = scent_val;
      end else if (btn_ok && step[1]) begin
         scent_d = (scent_q == SCENT_MAX) ? '0 : scent_q + SW'(1);
      end else if (btn_ok && step[0]) begin
         scent_d = (scent_q == '0) ? SCENT_MAX : scent_q - SW'(1);
      end
      if (tmr_take) begin
         timer_d = tmr_val;
      end else if (btn_ok && step[2]) begin
         timer_d = (timer_q == TIMER_MAX) ? 2'd0 : timer_q + 2'd1;
      end else if (btn_ok && step[3]) begin
         timer_d = (timer_q == 2'd0) ? TIMER_MAX : timer_q - 2'd1;
      end
   end

   assign changed_d = (scent_d != scent_q) | (timer_d != timer_q);

   always_comb begin
      src_d = src_q;
      if (changed_d) src_d = win_valid ? (3'(win_idx) + 3'd1) : SRC_BTN;
   end

   always_comb begin
      lock_d = lock_q;
      if (accept)             lock_d = LOCK_C;
      else if (lock_q != '0)  lock_d = lock_q - LW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scent_q   <= '0;
         timer_q   <= '0;
         changed_q <= 1'b0;
         src_q     <= '0;
         lock_q    <= '0;
         drop_q    <= 1'b0;
      end else begin
         scent_q   <= scent_d;
         timer_q   <= timer_d;
         changed_q <= changed_d;
         src_q     <= src_d;
         lock_q    <= lock_d;
         drop_q    <= drop_d;
      end
   end

   assign sel_scent_o   = scent_q;
   assign sel_timer_o   = timer_q;
   assign sel_changed_o = changed_q;
   assign sel_src_o     = src_q;
   assign btn_locked_o  = (lock_q != '0);
   assign cmd_drop_o    = drop_q;

endmodule
`default_nettype wire
